s100_bus_slave_responder: RTL and testbench
===========================================

// Module: s100_bus_slave_responder
// PURPOSE
//  S-100 bus slave: watches the master's status, strobes and address, and serves a
//  2^WIN_BITS-byte memory-mapped register window. Bus inputs are asynchronous to the clock.
//  Decodes the window, captures write data, drives read data with an output enable,
//  and holds n_pRDY low for programmable wait states. Sits on the slave-card FPGA.
// PARAMETERS
//  BASE_ADDR    20'hF0000  window base address; low WIN_BITS bits must be 0
//  WIN_BITS     4          window size 2^WIN_BITS bytes (1..8)
//  WAIT_STATES  2          clockIn cycles n_pRDY is held low on a read hit (0..15)
//  TIMEOUT      255        max clockIn cycles in RD_DRIVE/WR_WAIT before abort (8-bit)
// PORTS
//  clockIn       in   1   system clock
//  reset         in   1   asynchronous active-high reset
//  S100adr0_15   in   16  bus address A0..A15
//  S100adr16_19  in   4   bus extended address A16..A19
//  pSYNC         in   1   bus cycle start, active high
//  pSTVAL        in   1   status valid, active low
//  pDBIN         in   1   master read strobe, active high
//  n_pWR         in   1   master write strobe, active low
//  sMEMR         in   1   status: memory read
//  sMWRT         in   1   status: memory write
//  busDO         in   8   master data-out bus (write data)
//  busDI         out  8   slave read data to master
//  busDI_oe      out  1   enable for busDI pad drivers
//  n_pRDY        out  1   ready, low = insert wait
//  loc_addr      in   WIN_BITS  local read address into the window
//  loc_rdata     out  8   window byte at loc_addr (combinational)
//  wr_pulse      out  1   one-cycle pulse when a bus write lands
//  timeout_err   out  1   one-cycle pulse when a cycle is aborted on timeout
// BEHAVIOUR
//  - All bus inputs pass through 2-flop synchronizers. Edges are detected on the synced copies.
//    Address and data are sampled from the synced buses.
//  - Reset values: busDI=0, busDI_oe=0, n_pRDY=1, wr_pulse=0, timeout_err=0, state=IDLE,
//    window bytes=0.
//  - IDLE: on a synced pSYNC rising edge with pSTVAL low, latch address, sMEMR and sMWRT,
//    then go to DECODE.
//  - DECODE (1 cycle): hit = addr[19:WIN_BITS]==BASE_ADDR[19:WIN_BITS].
//      - miss -> IGNORE (wait for next pSYNC; no outputs).
//      - hit & sMEMR -> RD_WAIT, n_pRDY=0.
//      - hit & sMWRT -> WR_WAIT.
//      - hit with neither/both status bits -> IGNORE.
//  - RD_WAIT: count WAIT_STATES cycles, then release n_pRDY=1 and go to RD_DRIVE.
//    WAIT_STATES=0 -> n_pRDY never goes low; go directly to RD_DRIVE.
//  - RD_DRIVE: busDI=window[addr[WIN_BITS-1:0]]; busDI_oe=1 while synced pDBIN is high.
//    On pDBIN falling edge: busDI_oe=0 next cycle, go to IDLE.
//  - WR_WAIT: on synced n_pWR falling edge, write busDO into the window byte, pulse
//    wr_pulse, go to WR_DONE.
//  - WR_DONE: wait for n_pWR high, then go to IDLE.
//  - Timeout: an 8-bit counter resets on entry to RD_DRIVE/WR_WAIT. At TIMEOUT it forces
//    IDLE, busDI_oe=0, n_pRDY=1, and a timeout_err pulse.
//  - A pSYNC rising edge in any non-IDLE state aborts the current cycle: oe and rdy are
//    released that cycle, no write occurs, and the new address is latched (as from IDLE).
//  - Address wrap: the offset is the low WIN_BITS bits only; BASE+2^WIN_BITS is a miss.
//  - busDI_oe is never 1 while n_pWR (synced) is low.
//  - Async reset mid-cycle: oe drops and n_pRDY rises immediately.
//  - Same-cycle loc read and bus write: loc_rdata shows the old byte until the next clock.
// CONFIGURATION
//  S100_EXT_ADDR_EN defined: decode compares all 20 bits (A16..A19 included).
//  Not defined: A16..A19 are ignored and only addr[15:WIN_BITS] is compared, so the
//  window aliases in every 64K bank.
// TESTING
//  - Reset mid RD_DRIVE -> busDI_oe=0, n_pRDY=1 at once; the next valid cycle works normally.
//  - Write 0x5A to 0xF0003 -> wr_pulse once; loc_addr=3 gives loc_rdata=0x5A; no busDI_oe.
//  - Read 0xF0003, WAIT_STATES=2 -> n_pRDY low 2 cycles; busDI=0x5A with oe during pDBIN.
//  - Read 0xF0010 (miss) and 0xEFFFF -> n_pRDY stays 1, oe stays 0, window unchanged.
//  - Hold pDBIN high for 300 cycles -> abort at 255, timeout_err pulses, state IDLE.
//  - Access 0x00003 -> ignored with S100_EXT_ADDR_EN; hit (byte 3) without it.

Source files
------------

// File: rtl/s100_bus_slave_responder.sv
// S-100 bus slave: synchronizes the asynchronous bus, decodes a 2^WIN_BITS-byte register
// window, inserts read wait states and aborts stalled cycles. Optional macro: S100_EXT_ADDR_EN.
module s100_bus_slave_responder #(
  parameter logic [19:0] BASE_ADDR   = 20'hF0000,
  parameter int          WIN_BITS    = 4,
  parameter int          WAIT_STATES = 2,
  parameter int          TIMEOUT     = 255
) (
  input  logic                clockIn,
  input  logic                reset,
  input  logic [15:0]         S100adr0_15,
  input  logic [3:0]          S100adr16_19,
  input  logic                pSYNC,
  input  logic                pSTVAL,
  input  logic                pDBIN,
  input  logic                n_pWR,
  input  logic                sMEMR,
  input  logic                sMWRT,
  input  logic [7:0]          busDO,
  output logic [7:0]          busDI,
  output logic                busDI_oe,
  output logic                n_pRDY,
  input  logic [WIN_BITS-1:0] loc_addr,
  output logic [7:0]          loc_rdata,
  output logic                wr_pulse,
  output logic                timeout_err
);

  localparam int              WIN_SIZE = 1 << WIN_BITS;
  localparam int              SW       = 34;
  localparam logic [SW-1:0]   SYNC_RST = SW'(6'b010100);  // pSTVAL and n_pWR idle high
  localparam logic [7:0]      TO_LIM   = 8'(TIMEOUT);
  localparam logic [3:0]      WS_LAST  = 4'(WAIT_STATES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_RD_WAIT, S_RD_DRIVE, S_WR_WAIT, S_WR_DONE, S_IGNORE
  } state_t;

  logic [SW-1:0] raw, meta_q, sync_q;
  logic [3:0]    ext_s;
  logic [15:0]   adr_s;
  logic [7:0]    busdo_s;
  logic          psync_s, pstval_s, pdbin_s, npwr_s, smemr_s, smwrt_s;
  logic          psync_p_q, pdbin_p_q, npwr_p_q;
  logic          psync_rise, pdbin_fall, npwr_fall;

  assign raw = {S100adr16_19, S100adr0_15, busDO, pSYNC, pSTVAL, pDBIN, n_pWR, sMEMR, sMWRT};
  assign {ext_s, adr_s, busdo_s, psync_s, pstval_s, pdbin_s, npwr_s, smemr_s, smwrt_s} = sync_q;

  // NOTE: every clocked block uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clockIn or posedge reset) begin
    if (reset) begin
      meta_q    <= SYNC_RST;
      sync_q    <= SYNC_RST;
      psync_p_q <= 1'b0;
      pdbin_p_q <= 1'b0;
      npwr_p_q  <= 1'b1;
    end else begin
      meta_q    <= raw;
      sync_q    <= meta_q;
      psync_p_q <= psync_s;
      pdbin_p_q <= pdbin_s;
      npwr_p_q  <= npwr_s;
    end
  end

  assign psync_rise = psync_s & ~psync_p_q;
  assign pdbin_fall = ~pdbin_s & pdbin_p_q;
  assign npwr_fall  = ~npwr_s & npwr_p_q;

  state_t              state_q;
  logic [19:0]         addr_q;
  logic                memr_q, mwrt_q;
  logic [3:0]          wait_q;
  logic [7:0]          to_q;
  logic [7:0]          busdi_q;
  logic                oe_q, rdy_n_q, wr_pulse_q, to_err_q;
  logic [7:0]          window_q [WIN_SIZE];
  logic [WIN_BITS-1:0] off;
  logic                hit, timeout_hit;

  assign off = addr_q[WIN_BITS-1:0];

`ifdef S100_EXT_ADDR_EN
  assign hit = (addr_q[19:WIN_BITS] == BASE_ADDR[19:WIN_BITS]);
`else
  // A16..A19 are ignored, so the window aliases in every 64K bank.
  assign hit = (addr_q[15:WIN_BITS] == BASE_ADDR[15:WIN_BITS]);
  wire unused_ext = ^addr_q[19:16];
`endif

  assign timeout_hit = ((state_q == S_RD_DRIVE) || (state_q == S_WR_WAIT)) && (to_q == TO_LIM);

  always_ff @(posedge clockIn or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      memr_q     <= 1'b0;
      mwrt_q     <= 1'b0;
      wait_q     <= '0;
      to_q       <= '0;
      busdi_q    <= '0;
      oe_q       <= 1'b0;
      rdy_n_q    <= 1'b1;
      wr_pulse_q <= 1'b0;
      to_err_q   <= 1'b0;
      // NOTE: the window is a small register file that must read back as zero after reset,
      // so it is cleared here rather than inferred as an unreset RAM.
      for (int i = 0; i < WIN_SIZE; i++) window_q[i] <= '0;
    end else begin
      wr_pulse_q <= 1'b0;
      to_err_q   <= 1'b0;
      if (psync_rise && !pstval_s) begin
        addr_q  <= {ext_s, adr_s};
        memr_q  <= smemr_s;
        mwrt_q  <= smwrt_s;
        oe_q    <= 1'b0;
        rdy_n_q <= 1'b1;
        state_q <= S_DECODE;
      end else if (psync_rise && state_q != S_IDLE) begin
        oe_q    <= 1'b0;
        rdy_n_q <= 1'b1;
        state_q <= S_IDLE;
      end else if (timeout_hit) begin
        oe_q     <= 1'b0;
        rdy_n_q  <= 1'b1;
        to_err_q <= 1'b1;
        state_q  <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: state_q <= S_IDLE;
          S_DECODE: begin
            if (hit && memr_q && !mwrt_q) begin
              if (WAIT_STATES == 0) begin
                to_q    <= '0;
                state_q <= S_RD_DRIVE;
              end else begin
                wait_q  <= '0;
                rdy_n_q <= 1'b0;
                state_q <= S_RD_WAIT;
              end
            end else if (hit && mwrt_q && !memr_q) begin
              to_q    <= '0;
              state_q <= S_WR_WAIT;
            end else begin
              state_q <= S_IGNORE;
            end
          end
          S_RD_WAIT: begin
            if (wait_q == WS_LAST) begin
              rdy_n_q <= 1'b1;
              to_q    <= '0;
              state_q <= S_RD_DRIVE;
            end else begin
              wait_q <= wait_q + 4'd1;
            end
          end
          S_RD_DRIVE: begin
            busdi_q <= window_q[off];
            if (pdbin_fall) begin
              oe_q    <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              // Never drive the data bus while the master is writing.
              oe_q <= pdbin_s & npwr_s;
              to_q <= to_q + 8'd1;
            end
          end
          S_WR_WAIT: begin
            if (npwr_fall) begin
              window_q[off] <= busdo_s;
              wr_pulse_q    <= 1'b1;
              state_q       <= S_WR_DONE;
            end else begin
              to_q <= to_q + 8'd1;
            end
          end
          S_WR_DONE: if (npwr_s) state_q <= S_IDLE;
          S_IGNORE:  state_q <= S_IGNORE;
          default:   state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busDI       = busdi_q;
  assign busDI_oe    = oe_q;
  assign n_pRDY      = rdy_n_q;
  assign wr_pulse    = wr_pulse_q;
  assign timeout_err = to_err_q;
  assign loc_rdata   = window_q[loc_addr];

endmodule

// File: tb/tb_s100_bus_slave_responder.sv
// Self-checking bench for s100_bus_slave_responder: directed table, corner sequences and
// randomized bus cycles scored against a transaction-level window model.
module tb_s100_bus_slave_responder;

  localparam logic [19:0] BASE = 20'hF0000;
  localparam int          WIN  = 4;
  localparam int          WS   = 2;
  localparam int          TO   = 255;

  logic        clockIn = 1'b0;
  logic        reset;
  logic [15:0] S100adr0_15;
  logic [3:0]  S100adr16_19;
  logic        pSYNC, pSTVAL, pDBIN, n_pWR, sMEMR, sMWRT;
  logic [7:0]  busDO, busDI, loc_rdata;
  logic        busDI_oe, n_pRDY, wr_pulse, timeout_err;
  logic [WIN-1:0] loc_addr;

  s100_bus_slave_responder #(
    .BASE_ADDR(BASE), .WIN_BITS(WIN), .WAIT_STATES(WS), .TIMEOUT(TO)
  ) dut (
    .clockIn(clockIn), .reset(reset), .S100adr0_15(S100adr0_15), .S100adr16_19(S100adr16_19),
    .pSYNC(pSYNC), .pSTVAL(pSTVAL), .pDBIN(pDBIN), .n_pWR(n_pWR), .sMEMR(sMEMR), .sMWRT(sMWRT),
    .busDO(busDO), .busDI(busDI), .busDI_oe(busDI_oe), .n_pRDY(n_pRDY), .loc_addr(loc_addr),
    .loc_rdata(loc_rdata), .wr_pulse(wr_pulse), .timeout_err(timeout_err)
  );

  always #5 clockIn = ~clockIn;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction monitor: counts what the slave did during one bus cycle.
  bit         mon_en = 0;
  int         mon_rdy_low, mon_oe, mon_wr, mon_to, mon_bad_data;
  logic [7:0] mon_exp;

  always @(negedge clockIn) begin
    if (mon_en) begin
      if (n_pRDY === 1'b0) mon_rdy_low++;
      if (busDI_oe === 1'b1) begin
        mon_oe++;
        if (busDI !== mon_exp) mon_bad_data++;
      end
      if (wr_pulse === 1'b1) mon_wr++;
      if (timeout_err === 1'b1) mon_to++;
    end
  end

  task automatic mon_start(input logic [7:0] exp_data);
    mon_rdy_low = 0; mon_oe = 0; mon_wr = 0; mon_to = 0; mon_bad_data = 0;
    mon_exp = exp_data;
    mon_en  = 1;
  endtask

  logic [7:0] model [16];

  function automatic bit model_hit(input logic [19:0] a);
`ifdef S100_EXT_ADDR_EN
    return (int'(a) >> WIN) == (int'(BASE) >> WIN);
`else
    return ((int'(a) % 65536) >> WIN) == ((int'(BASE) % 65536) >> WIN);
`endif
  endfunction

  task automatic bus_cycle(input logic [19:0] a, input bit rd, input bit wr,
                           input logic [7:0] d, input int dbin_len);
    @(negedge clockIn);
    {S100adr16_19, S100adr0_15} = a;
    sMEMR = rd; sMWRT = wr; busDO = d;
    pSTVAL = 1'b0; pSYNC = 1'b1;
    repeat (3) @(negedge clockIn);
    pSYNC = 1'b0; pSTVAL = 1'b1;
    repeat (8) @(negedge clockIn);
    if (rd && !wr) begin
      pDBIN = 1'b1;
      repeat (dbin_len) @(negedge clockIn);
      pDBIN = 1'b0;
    end else if (wr && !rd) begin
      n_pWR = 1'b0;
      repeat (4) @(negedge clockIn);
      n_pWR = 1'b1;
    end
    repeat (8) @(negedge clockIn);
    sMEMR = 1'b0; sMWRT = 1'b0;
  endtask

  task automatic run_txn(input string name, input logic [19:0] a, input bit rd, input bit wr,
                         input logic [7:0] d, input int exp_rdy, input bit exp_oe,
                         input logic [7:0] exp_data, input bit exp_wr, input logic [7:0] exp_loc);
    mon_start(exp_data);
    bus_cycle(a, rd, wr, d, 6);
    mon_en = 0;
    check({name, ".rdy_low"}, mon_rdy_low, exp_rdy);
    check({name, ".oe_seen"}, 32'(mon_oe > 0), 32'(exp_oe));
    check({name, ".rd_data"}, mon_bad_data, 0);
    check({name, ".wr_pulses"}, mon_wr, 32'(exp_wr));
    check({name, ".timeouts"}, mon_to, 0);
    loc_addr = a[WIN-1:0];
    #1;
    check({name, ".loc_rdata"}, loc_rdata, exp_loc);
  endtask

  typedef struct {
    logic [19:0] addr;
    bit          rd, wr;
    logic [7:0]  data;
    int          exp_rdy;
    bit          exp_oe;
    logic [7:0]  exp_data;
    bit          exp_wr;
    logic [7:0]  exp_loc;
  } vec_t;

  vec_t vecs [11];

  initial begin
    reset = 1'b1;
    S100adr0_15 = '0; S100adr16_19 = '0; pSYNC = 1'b0; pSTVAL = 1'b1; pDBIN = 1'b0;
    n_pWR = 1'b1; sMEMR = 1'b0; sMWRT = 1'b0; busDO = '0; loc_addr = '0;
    for (int i = 0; i < 16; i++) model[i] = '0;

    vecs[0]  = '{20'hF0003, 1'b0, 1'b1, 8'h5A, 0,  1'b0, 8'h00, 1'b1, 8'h5A};
    vecs[1]  = '{20'hF0003, 1'b1, 1'b0, 8'h00, WS, 1'b1, 8'h5A, 1'b0, 8'h5A};
    vecs[2]  = '{20'hF0010, 1'b1, 1'b0, 8'h00, 0,  1'b0, 8'h00, 1'b0, 8'h00};
    vecs[3]  = '{20'hEFFFF, 1'b1, 1'b0, 8'h00, 0,  1'b0, 8'h00, 1'b0, 8'h00};
    vecs[4]  = '{20'hF0010, 1'b0, 1'b1, 8'hFF, 0,  1'b0, 8'h00, 1'b0, 8'h00};
`ifdef S100_EXT_ADDR_EN
    vecs[5]  = '{20'h00003, 1'b1, 1'b0, 8'h00, 0,  1'b0, 8'h00, 1'b0, 8'h5A};
    vecs[6]  = '{20'h00007, 1'b0, 1'b1, 8'h11, 0,  1'b0, 8'h00, 1'b0, 8'h00};
    vecs[7]  = '{20'hF0007, 1'b1, 1'b0, 8'h00, WS, 1'b1, 8'h00, 1'b0, 8'h00};
`else
    vecs[5]  = '{20'h00003, 1'b1, 1'b0, 8'h00, WS, 1'b1, 8'h5A, 1'b0, 8'h5A};
    vecs[6]  = '{20'h00007, 1'b0, 1'b1, 8'h11, 0,  1'b0, 8'h00, 1'b1, 8'h11};
    vecs[7]  = '{20'hF0007, 1'b1, 1'b0, 8'h00, WS, 1'b1, 8'h11, 1'b0, 8'h11};
`endif
    vecs[8]  = '{20'hF0001, 1'b1, 1'b1, 8'h22, 0,  1'b0, 8'h00, 1'b0, 8'h00};
    vecs[9]  = '{20'hF000F, 1'b0, 1'b1, 8'hC3, 0,  1'b0, 8'h00, 1'b1, 8'hC3};
    vecs[10] = '{20'hF000F, 1'b1, 1'b0, 8'h00, WS, 1'b1, 8'hC3, 1'b0, 8'hC3};

    // Reset state
    repeat (3) @(negedge clockIn);
    check("rst.busDI", busDI, 8'h00);
    check("rst.oe", busDI_oe, 1'b0);
    check("rst.rdy", n_pRDY, 1'b1);
    reset = 1'b0;
    repeat (2) @(negedge clockIn);
    check("rst.wr_pulse", wr_pulse, 1'b0);
    check("rst.timeout_err", timeout_err, 1'b0);
    loc_addr = 4'd3; #1;
    check("rst.loc3", loc_rdata, 8'h00);

    // Directed vectors
    for (int i = 0; i < 11; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].data,
              vecs[i].exp_rdy, vecs[i].exp_oe, vecs[i].exp_data, vecs[i].exp_wr, vecs[i].exp_loc);
      if (vecs[i].exp_wr) model[vecs[i].addr[WIN-1:0]] = vecs[i].data;
    end

    // pDBIN held far past the timeout
    mon_start(model[3]);
    bus_cycle(20'hF0003, 1'b1, 1'b0, 8'h00, 300);
    mon_en = 0;
    check("to.pulses", mon_to, 1);
    check("to.oe_len_in_range", 32'(mon_oe >= 230 && mon_oe <= 260), 1);
    check("to.rd_data", mon_bad_data, 0);
    check("to.rdy_low", mon_rdy_low, WS);
    check("to.oe_after", busDI_oe, 1'b0);
    check("to.rdy_after", n_pRDY, 1'b1);
    run_txn("after_to", 20'hF0003, 1'b1, 1'b0, 8'h00, WS, 1'b1, model[3], 1'b0, model[3]);

    // New pSYNC landing on the same edge as the write strobe aborts the write
    mon_start(8'h00);
    @(negedge clockIn);
    {S100adr16_19, S100adr0_15} = 20'hF0005;
    sMWRT = 1'b1; sMEMR = 1'b0; busDO = 8'h77; pSTVAL = 1'b0; pSYNC = 1'b1;
    repeat (3) @(negedge clockIn);
    pSYNC = 1'b0; pSTVAL = 1'b1;
    repeat (6) @(negedge clockIn);
    {S100adr16_19, S100adr0_15} = 20'hF0010;
    sMEMR = 1'b1; sMWRT = 1'b0; pSTVAL = 1'b0; pSYNC = 1'b1; n_pWR = 1'b0;
    repeat (4) @(negedge clockIn);
    pSYNC = 1'b0; pSTVAL = 1'b1; n_pWR = 1'b1; sMEMR = 1'b0;
    repeat (8) @(negedge clockIn);
    mon_en = 0;
    check("abort.wr_pulses", mon_wr, 0);
    check("abort.rdy_low", mon_rdy_low, 0);
    check("abort.oe", mon_oe, 0);
    loc_addr = 4'd5; #1;
    check("abort.loc5", loc_rdata, model[5]);

    // Randomized cycles against the window model
    for (int i = 0; i < 40; i++) begin
      int unsigned k, sel;
      logic [3:0]  off;
      logic [19:0] a;
      logic [7:0]  d;
      bit          rd, wr, rh, wh;
      k   = $urandom_range(0, 9);
      sel = $urandom_range(0, 9);
      off = 4'($urandom_range(0, 15));
      d   = 8'($urandom);
      rd  = (k <= 3) || (k == 9);
      wr  = (k >= 4 && k <= 7) || (k == 9);
      if (sel <= 5)      a = BASE + 20'(off);
      else if (sel == 6) a = BASE + 20'd16 + 20'(off);
      else if (sel == 7) a = 20'hEFFF0 + 20'(off);
      else if (sel == 8) a = {4'($urandom_range(0, 15)), 12'h000, off};
      else               a = {4'hF, 16'($urandom)};
      rh = model_hit(a) && rd && !wr;
      wh = model_hit(a) && wr && !rd;
      if (wh) model[a[WIN-1:0]] = d;
      run_txn($sformatf("rnd%0d", i), a, rd, wr, d, rh ? WS : 0, rh, model[a[WIN-1:0]], wh,
              model[a[WIN-1:0]]);
    end

    // Read in progress: write strobe gates the driver, then async reset mid-drive
    @(negedge clockIn);
    {S100adr16_19, S100adr0_15} = 20'hF0003;
    sMEMR = 1'b1; pSTVAL = 1'b0; pSYNC = 1'b1;
    repeat (3) @(negedge clockIn);
    pSYNC = 1'b0; pSTVAL = 1'b1;
    repeat (8) @(negedge clockIn);
    pDBIN = 1'b1;
    repeat (5) @(negedge clockIn);
    check("mid.oe_on", busDI_oe, 1'b1);
    check("mid.busDI", busDI, model[3]);
    n_pWR = 1'b0;
    repeat (4) @(negedge clockIn);
    check("mid.oe_gated_by_wr", busDI_oe, 1'b0);
    n_pWR = 1'b1;
    repeat (4) @(negedge clockIn);
    check("mid.oe_back", busDI_oe, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("mid.rst_oe", busDI_oe, 1'b0);
    check("mid.rst_rdy", n_pRDY, 1'b1);
    check("mid.rst_busDI", busDI, 8'h00);
    pDBIN = 1'b0; sMEMR = 1'b0;
    repeat (2) @(negedge clockIn);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    loc_addr = 4'd3; #1;
    check("mid.rst_loc3", loc_rdata, 8'h00);
    repeat (2) @(negedge clockIn);

    run_txn("post_rst_rd", 20'hF0003, 1'b1, 1'b0, 8'h00, WS, 1'b1, 8'h00, 1'b0, 8'h00);
    run_txn("post_rst_wr", 20'hF0009, 1'b0, 1'b1, 8'hA5, 0, 1'b0, 8'h00, 1'b1, 8'hA5);
    run_txn("post_rst_rd9", 20'hF0009, 1'b1, 1'b0, 8'h00, WS, 1'b1, 8'hA5, 1'b0, 8'hA5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
